// File: rtl/shift_rotate_core.sv
// shift_rotate_core: parametrised shift/rotate MMIO peripheral on the slot bus.
// An operation is started by a CTRL write with start=1. OPERAND, shamt and
// mode are snapshotted, and RESULT and done appear STAGES cycles later.
// Optional feature macro: SHIFT_CORE_FLAGS_EN enables the zero/carry/overrun flags.
// When the macro is undefined, STATUS[4:2] read as 0.
module shift_rotate_core #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(STAGES + 1);

    localparam logic [4:0] ADDR_OPERAND = 5'd0;
    localparam logic [4:0] ADDR_CTRL    = 5'd1;
    localparam logic [4:0] ADDR_RESULT  = 5'd2;
    localparam logic [4:0] ADDR_STATUS  = 5'd3;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    operand_q;
    logic [SW-1:0]   shamt_q;
    logic [1:0]      mode_q;
    logic [W-1:0]    opOperand_q;
    logic [SW-1:0]   opShamt_q;
    logic [1:0]      opMode_q;
    logic [W-1:0]    result_q;
    logic            done_q;
    logic [31:0]     rdData_q;
`ifdef SHIFT_CORE_FLAGS_EN
    logic            zero_q;
    logic            carry_q;
    logic            overrun_q;
`endif

    logic [W-1:0]    shiftRes_d;
    logic            shiftCarry_d;
    logic [W-1:0]    lslPre;
    logic [W-1:0]    rsPre;
    logic [2*W-1:0]  rorWide;
    logic [31:0]     rdMux_d;
    logic            wrOperand;
    logic            wrCtrl;
    logic            wrStatus;
    logic            startReq;
    logic            busy;
    logic            unused_inputs;

    assign wrOperand = cs && write && (addr == ADDR_OPERAND);
    assign wrCtrl    = cs && write && (addr == ADDR_CTRL);
    assign wrStatus  = cs && write && (addr == ADDR_STATUS);
    assign startReq  = wrCtrl && wr_data[8];
    assign busy      = (state_q == RUN);
    assign rd_data   = rdData_q;

    // Shift/rotate datapath working on the snapshot of the in-flight operation.
    // The carry is the last bit shifted out, taken one position short of the full shift.
    always_comb begin
        shiftRes_d   = opOperand_q;
        shiftCarry_d = 1'b0;
        lslPre       = opOperand_q << (opShamt_q - SW'(1));
        rsPre        = opOperand_q >> (opShamt_q - SW'(1));
        rorWide      = {opOperand_q, opOperand_q} >> opShamt_q;
        if (opShamt_q != '0) begin
            case (opMode_q)
                MODE_LSL: begin
                    shiftRes_d   = opOperand_q << opShamt_q;
                    shiftCarry_d = lslPre[W-1];
                end
                MODE_LSR: begin
                    shiftRes_d   = opOperand_q >> opShamt_q;
                    shiftCarry_d = rsPre[0];
                end
                MODE_ASR: begin
                    shiftRes_d   = $signed(opOperand_q) >>> opShamt_q;
                    shiftCarry_d = rsPre[0];
                end
                MODE_ROR: begin
                    shiftRes_d   = rorWide[W-1:0];
                    shiftCarry_d = rorWide[W-1];
                end
                default: begin
                    shiftRes_d   = opOperand_q;
                    shiftCarry_d = 1'b0;
                end
            endcase
        end
    end

    // Control FSM plus the register file.
    // For done, the W1C clear comes before the completion set, so a set in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            operand_q   <= '0;
            shamt_q     <= '0;
            mode_q      <= '0;
            opOperand_q <= '0;
            opShamt_q   <= '0;
            opMode_q    <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
`ifdef SHIFT_CORE_FLAGS_EN
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overrun_q   <= 1'b0;
`endif
        end else begin
            if (wrOperand) begin
                operand_q <= wr_data[W-1:0];
            end
            if (wrCtrl) begin
                shamt_q <= wr_data[SW-1:0];
                mode_q  <= wr_data[6:5];
            end
            if (wrStatus && wr_data[1]) begin
                done_q <= 1'b0;
            end
`ifdef SHIFT_CORE_FLAGS_EN
            if (wrStatus && wr_data[4]) begin
                overrun_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (startReq) begin
                        opOperand_q <= operand_q;
                        opShamt_q   <= wr_data[SW-1:0];
                        opMode_q    <= wr_data[6:5];
                        cnt_q       <= CW'(STAGES);
                        done_q      <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
`ifdef SHIFT_CORE_FLAGS_EN
                    if (startReq) begin
                        overrun_q <= 1'b1;
                    end
`endif
                    if (cnt_q == CW'(1)) begin
                        result_q <= shiftRes_d;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
`ifdef SHIFT_CORE_FLAGS_EN
                        zero_q   <= (shiftRes_d == '0);
                        carry_q  <= shiftCarry_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read multiplexer. Unmapped addresses and unused bits return 0.
    always_comb begin
        rdMux_d = '0;
        case (addr)
            ADDR_OPERAND: rdMux_d[W-1:0] = operand_q;
            ADDR_CTRL: begin
                rdMux_d[SW-1:0] = shamt_q;
                rdMux_d[6:5]    = mode_q;
            end
            ADDR_RESULT:  rdMux_d[W-1:0] = result_q;
            ADDR_STATUS: begin
                rdMux_d[0] = busy;
                rdMux_d[1] = done_q;
`ifdef SHIFT_CORE_FLAGS_EN
                rdMux_d[2] = zero_q;
                rdMux_d[3] = carry_q;
                rdMux_d[4] = overrun_q;
`endif
            end
            default: rdMux_d = '0;
        endcase
    end

    // Registered read data, which only changes on a qualified read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdData_q <= '0;
        end else if (cs && read) begin
            rdData_q <= rdMux_d;
        end
    end

`ifdef SHIFT_CORE_FLAGS_EN
    assign unused_inputs = ^wr_data;
`else
    assign unused_inputs = ^{wr_data, shiftCarry_d};
`endif

endmodule

// File: tb/tb_shift_rotate_core.sv
// tb_shift_rotate_core: self-checking bench for shift_rotate_core (W=32, STAGES=2).
// Expected flag bits follow SHIFT_CORE_FLAGS_EN so the bench suits either build.
module tb_shift_rotate_core;
    localparam int W      = 32;
    localparam int STAGES = 2;
`ifdef SHIFT_CORE_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    int checks;
    int errors;

    shift_rotate_core #(.W(W), .STAGES(STAGES)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cs(cs),
        .read(read),
        .write(write),
        .addr(addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so that the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour, computed with plain 64-bit arithmetic
    function automatic void refModel(input logic [31:0] op, input int n, input int mode,
                                     output logic [31:0] res, output logic carry);
        longint unsigned v;
        longint unsigned full;
        longint unsigned r;
        v     = 64'(op);
        full  = 64'hFFFF_FFFF;
        r     = v;
        carry = 1'b0;
        if (n != 0) begin
            case (mode)
                0: begin
                    r     = (v << n) & full;
                    carry = ((v >> (W - n)) & 64'd1) != 0;
                end
                1: begin
                    r     = v >> n;
                    carry = ((v >> (n - 1)) & 64'd1) != 0;
                end
                2: begin
                    r = v >> n;
                    if (v >= 64'h8000_0000) r = r | ((full << (W - n)) & full);
                    carry = ((v >> (n - 1)) & 64'd1) != 0;
                end
                default: begin
                    r     = ((v >> n) | (v << (W - n))) & full;
                    carry = r >= 64'h8000_0000;
                end
            endcase
        end
        res = r[31:0];
    endfunction

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0; addr = '0;
        d = rd_data;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] ctrlWord(input int shamt, input int mode, input bit start);
        logic [31:0] w;
        w      = '0;
        w[4:0] = shamt[4:0];
        w[6:5] = mode[1:0];
        w[8]   = start;
        return w;
    endfunction

    // Poll STATUS until done shows, returning how many reads that took (-1 if never)
    task automatic waitDone(output int latency, output logic busySeen);
        logic [31:0] st;
        latency  = -1;
        busySeen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            busRead(5'd3, st);
            if (i == 1) busySeen = st[0];
            if (st[1]) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic runOp(input logic [31:0] op, input int shamt, input int mode,
                         output int latency, output logic busySeen,
                         output logic [31:0] res, output logic [31:0] st);
        busWrite(5'd0, op);
        busWrite(5'd1, ctrlWord(shamt, mode, 1'b1));
        waitDone(latency, busySeen);
        busRead(5'd2, res);
        busRead(5'd3, st);
    endtask

    function automatic logic [31:0] expStatus(input logic zero, input logic carry, input logic ovr);
        logic [31:0] s;
        s = 32'h2;
        if (FLAGS_EN) begin
            s[2] = zero;
            s[3] = carry;
            s[4] = ovr;
        end
        return s;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rd_data got %h expected %h", rd_data, 32'h0);
        end
        for (int a = 0; a < 4; a++) begin
            busRead(5'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++; $display("[TB] FAIL reset_reg%0d got %h expected %h", a, d, 32'h0);
            end
        end
    endtask

    task automatic test_directed(input string name, input logic [31:0] op, input int n,
                                 input int mode, input logic [31:0] expRes,
                                 input logic expZero, input logic expCarry);
        int lat; logic bsy; logic [31:0] res; logic [31:0] st;
        runOp(op, n, mode, lat, bsy, res, st);
        checks++;
        if (lat !== STAGES + 1) begin
            errors++; $display("[TB] FAIL %s_latency got %0d expected %0d", name, lat, STAGES + 1);
        end
        checks++;
        if (bsy !== 1'b1) begin
            errors++; $display("[TB] FAIL %s_busy got %b expected 1", name, bsy);
        end
        checks++;
        if (res !== expRes) begin
            errors++; $display("[TB] FAIL %s_result got %h expected %h", name, res, expRes);
        end
        checks++;
        if (st !== expStatus(expZero, expCarry, 1'b0)) begin
            errors++; $display("[TB] FAIL %s_status got %h expected %h", name, st,
                               expStatus(expZero, expCarry, 1'b0));
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        busWrite(5'd1, 32'h0000_0047);
        busRead(5'd1, d);
        checks++;
        if (d !== 32'h0000_0047) begin
            errors++; $display("[TB] FAIL ctrl_readback got %h expected %h", d, 32'h47);
        end
        busWrite(5'd5, 32'hDEAD_BEEF);
        busRead(5'd5, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL unmapped_read got %h expected %h", d, 32'h0);
        end
        busWrite(5'd0, 32'hA5A5_1234);
        busRead(5'd0, d);
        checks++;
        if (d !== 32'hA5A5_1234) begin
            errors++; $display("[TB] FAIL operand_readback got %h expected %h", d, 32'hA5A5_1234);
        end
        repeat (3) idleCycle();
        checks++;
        if (rd_data !== 32'hA5A5_1234) begin
            errors++; $display("[TB] FAIL rd_data_hold got %h expected %h", rd_data, 32'hA5A5_1234);
        end
    endtask

    task automatic test_overrun();
        int lat; logic bsy; logic [31:0] d;
        busWrite(5'd0, 32'h1);
        busWrite(5'd1, ctrlWord(4, 0, 1'b1));
        busWrite(5'd0, 32'hF);
        busWrite(5'd1, ctrlWord(4, 0, 1'b1));
        waitDone(lat, bsy);
        busRead(5'd2, d);
        checks++;
        if (d !== 32'h10) begin
            errors++; $display("[TB] FAIL overrun_result got %h expected %h", d, 32'h10);
        end
        busRead(5'd3, d);
        checks++;
        if (d !== expStatus(1'b0, 1'b0, 1'b1)) begin
            errors++; $display("[TB] FAIL overrun_status got %h expected %h", d, expStatus(1'b0, 1'b0, 1'b1));
        end
        busRead(5'd0, d);
        checks++;
        if (d !== 32'hF) begin
            errors++; $display("[TB] FAIL overrun_operand got %h expected %h", d, 32'hF);
        end
        busRead(5'd1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("[TB] FAIL overrun_ctrl got %h expected %h", d, 32'h4);
        end
        busWrite(5'd3, 32'h12);
        busRead(5'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL status_w1c got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic bsy; logic [31:0] d;
        busWrite(5'd0, 32'h3);
        busWrite(5'd1, ctrlWord(1, 0, 1'b1));
        busWrite(5'd0, 32'h0000_F000);
        repeat (STAGES - 1) idleCycle();
        busWrite(5'd1, ctrlWord(12, 3, 1'b1));
        waitDone(lat, bsy);
        checks++;
        if (lat !== STAGES + 1) begin
            errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", lat, STAGES + 1);
        end
        busRead(5'd2, d);
        checks++;
        if (d !== 32'h0000_000F) begin
            errors++; $display("[TB] FAIL b2b_result got %h expected %h", d, 32'hF);
        end
        busRead(5'd3, d);
        checks++;
        if (d !== expStatus(1'b0, 1'b0, 1'b0)) begin
            errors++; $display("[TB] FAIL b2b_status got %h expected %h", d, expStatus(1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        int lat; logic bsy; logic [31:0] res; logic [31:0] st;
        logic [31:0] op; logic [31:0] eRes; logic eCarry;
        int n; int mode;
        for (int i = 0; i < 24; i++) begin
            op   = $urandom;
            n    = $urandom_range(0, 31);
            mode = $urandom_range(0, 3);
            if (i == 0) op = 32'h0;
            refModel(op, n, mode, eRes, eCarry);
            runOp(op, n, mode, lat, bsy, res, st);
            checks++;
            if (res !== eRes) begin
                errors++; $display("[TB] FAIL rand%0d_result op=%h n=%0d mode=%0d got %h expected %h",
                                   i, op, n, mode, res, eRes);
            end
            checks++;
            if (st !== expStatus(eRes == 0, eCarry, 1'b0)) begin
                errors++; $display("[TB] FAIL rand%0d_status op=%h n=%0d mode=%0d got %h expected %h",
                                   i, op, n, mode, st, expStatus(eRes == 0, eCarry, 1'b0));
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        busWrite(5'd0, 32'h0F0F_0F0F);
        busWrite(5'd1, ctrlWord(4, 0, 1'b1));
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("[TB] FAIL midrun_rd_data got %h expected %h", rd_data, 32'h0);
        end
        busRead(5'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL midrun_status got %h expected %h", d, 32'h0);
        end
        busRead(5'd2, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL midrun_result got %h expected %h", d, 32'h0);
        end
        test_directed("post_reset", 32'h0F0F_0F0F, 4, 0, 32'hF0F0_F0F0, 1'b0, 1'b0);
    endtask

    // Test sequence
    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_directed("lsl", 32'h8000_0001, 1, 0, 32'h0000_0002, 1'b0, 1'b1);
        test_directed("asr", 32'h8000_0000, 8, 2, 32'hFF80_0000, 1'b0, 1'b0);
        test_directed("ror", 32'h1234_5678, 4, 3, 32'h8123_4567, 1'b0, 1'b1);
        test_directed("lsr", 32'h4000_0000, 31, 1, 32'h0000_0000, 1'b1, 1'b1);
        test_directed("shamt0", 32'hC3C3_0001, 0, 2, 32'hC3C3_0001, 1'b0, 1'b0);
        test_regs();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rotate_core.md
# shift_rotate_core

Parametrised, pipelined shift/rotate peripheral core on the standard slot bus (cs/read/write/addr/wr_data/rd_data). It succeeds the fixed 32-bit barrel-shift core with a configurable data width and pipeline depth, four shift modes, and an explicit start/busy/done handshake. It also adds status flags (zero, carry-out, overrun) and a registered read path. It plugs into any MMIO slot of the microcontroller fabric.

## Interface
- W, default 32: operand/result width; legal values 8, 16, 32. SW = clog2(W) is the shift-amount width.
- STAGES, default 2: pipeline registers inside the shifter; legal range 1..SW.
- clk  input  1  system clock, all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  slot select; reads and writes are ignored when low.
- read  input  1  read strobe, qualified by cs.
- write  input  1  write strobe, qualified by cs.
- addr  input  5  word register address.
- wr_data  input  32  write data.
- rd_data  output  32  registered read data.

## Operation
- Register map (addr): 0 OPERAND (R/W, bits W-1:0, upper bits read 0).
- 1 CTRL (R/W): [SW-1:0] shamt, [6:5] mode (00 LSL, 01 LSR, 10 ASR, 11 ROR), [8] start (write-only, self-clearing, reads 0).
- 2 RESULT (R, bits W-1:0).
- 3 STATUS (R): [0] busy, [1] done, [2] zero, [3] carry, [4] overrun. Writing 1 to bit 1 clears done; writing 1 to bit 4 clears overrun (W1C).
- Unmapped addresses read 0; writes to them are ignored.
- FSM states: IDLE and RUN.
  - IDLE: a CTRL write with start=1 snapshots OPERAND, shamt and mode, clears done, and enters RUN.
  - RUN: a down-counter loaded with STAGES. At zero, RESULT and the flags load, done sets, and the FSM returns to IDLE.
- OPERAND and CTRL writes during RUN update the registers but do not affect the in-flight operation. A start during RUN is dropped and sets overrun.
- Arithmetic, with n = shamt:
  - LSL: zero-fill; carry = operand[W-n].
  - LSR: zero-fill; carry = operand[n-1].
  - ASR: fill with operand[W-1]; carry = operand[n-1].
  - ROR: carry = result[W-1].
  - n = 0: result = operand, carry = 0, all modes.
- zero = (result == 0).
- A W1C write to STATUS in the same cycle that done sets: the set wins.

## Timing
- Reset values: rd_data=0, all registers 0, FSM IDLE, busy=0, done=0, all flags 0.
- Start write sampled at edge T. busy=1 from T+1; RESULT, flags and done update at edge T+STAGES; busy=0 from the same edge.
- Back-to-back operations: a new start is accepted at the edge immediately after done sets.
- Read path: cs&&read sampled at edge T gives rd_data valid after edge T. rd_data holds until the next qualified read.
- Reset mid-RUN: the operation is abandoned and all state returns to reset values. The next start behaves as the first after reset.

## Configuration
- SHIFT_CORE_FLAGS_EN defined: zero, carry and overrun flags are implemented as described.
- SHIFT_CORE_FLAGS_EN undefined: flag logic is removed. STATUS[4:2] read 0, and the bit-4 W1C write is ignored. busy and done behave unchanged.

## Test plan
All scenarios use W=32, STAGES=2.
- LSL: OPERAND=0x8000_0001, CTRL shamt=1 mode=LSL start -> busy for 2 cycles, RESULT=0x0000_0002, carry=1, zero=0, done=1.
- ASR: OPERAND=0x8000_0000, shamt=8 mode=ASR -> RESULT=0xFF80_0000, carry=0.
- ROR: OPERAND=0x1234_5678, shamt=4 mode=ROR -> RESULT=0x8123_4567, carry=1.
- LSR: OPERAND=0x4000_0000, shamt=31 mode=LSR -> RESULT=0, zero=1, carry=1.
- Overrun: start (LSL 4 on 0x1), then start again 1 cycle later with OPERAND=0xF -> RESULT=0x10, overrun=1. STATUS write 0x12 -> done=0, overrun=0.
- Reset during RUN: reset_n low for 1 cycle while busy=1 -> busy=0, done=0, RESULT=0, rd_data=0. A new start completes normally.
